memory_8x32_ctrl: RTL and testbench

Initiator-side controller for the 8-location, 32-bit single-ported synchronous SRAM (`memory_8x32`). It accepts burst read/write commands from a client over valid/ready handshakes. It sequences one memory access per beat and absorbs the SRAM's one-cycle read latency. Read data is returned to the client with backpressure support. It sits between a client (CPU stub, DMA or testbench driver) and the SRAM, and is the only agent driving the SRAM ports.

---
 rtl/memory_8x32_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_memory_8x32_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_8x32_ctrl.sv
// ---------------------------------------------------------------------------
// memory_8x32_ctrl
//
// Initiator-side controller for the 8-word x 32-bit single-ported synchronous
// SRAM. A client issues burst commands (start address plus beat count) over a
// valid/ready handshake. The controller then issues one SRAM access per beat.
// Write beats stream straight through to the SRAM. For reads, the one-cycle
// SRAM latency is absorbed, and each read beat is held in an output register
// until the client accepts it.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   req_valid/req_ready    command handshake (ready only while idle)
//   req_write              1 = write burst, 0 = read burst
//   req_addr               burst start address (wraps modulo 8)
//   req_len                beats minus one
//   wvalid/wready/wdata    write beat channel
//   rvalid/rready/rdata    read beat channel (rvalid/rdata registered)
//   done                   one-cycle pulse after the final beat of a burst
//   busy                   controller is not idle
//   mem_address            SRAM address
//   mem_write_enable       SRAM write enable (1 = write, 0 = read)
//   mem_write_data         SRAM write data
//   mem_read_data          SRAM read data, valid one cycle after the address
// ---------------------------------------------------------------------------
module memory_8x32_ctrl #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_len,

    input  logic              wvalid,
    output logic              wready,
    input  logic [DATA_W-1:0] wdata,

    output logic              rvalid,
    input  logic              rready,
    output logic [DATA_W-1:0] rdata,

    output logic              done,
    output logic              busy,

    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write_enable,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ADDR,
        RD_CAP,
        RD_OUT
    } state_t;

    state_t            state;
    state_t            next_state;

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              write_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic              done_q;

    // The burst ends on the beat that sees a zero remaining-beat count.
    logic              last_beat;
    assign last_beat = (cnt_q == '0);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A read beat walks RD_ADDR -> RD_CAP -> RD_OUT. A
    // stalled RD_OUT therefore issues no further SRAM read until the client
    // accepts the held beat.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    next_state = req_write ? WR : RD_ADDR;
                end
            end
            WR: begin
                if (wvalid && last_beat) begin
                    next_state = IDLE;
                end
            end
            RD_ADDR: begin
                next_state = RD_CAP;
            end
            RD_CAP: begin
                next_state = RD_OUT;
            end
            RD_OUT: begin
                if (rready) begin
                    next_state = last_beat ? IDLE : RD_ADDR;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Burst bookkeeping and the read output register. The address counter is
    // exactly ADDR_W bits wide, so the increment wraps naturally from 7 to 0.
    // done is registered so that it appears in the first idle cycle after the
    // final beat, which is also the cycle in which req_ready is high again.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q   <= '0;
            cnt_q    <= '0;
            write_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        cnt_q   <= req_len;
                        write_q <= req_write;
                    end
                end
                WR: begin
                    if (wvalid) begin
                        if (last_beat) begin
                            done_q <= 1'b1;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                            cnt_q  <= cnt_q - ADDR_W'(1);
                        end
                    end
                end
                RD_CAP: begin
                    rdata_q  <= mem_read_data;
                    rvalid_q <= 1'b1;
                end
                RD_OUT: begin
                    if (rready) begin
                        rvalid_q <= 1'b0;
                        if (last_beat) begin
                            done_q <= 1'b1;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                            cnt_q  <= cnt_q - ADDR_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The SRAM sees the burst address and the client write data at all times.
    // It is written only on an accepted write beat. write_q keeps a write
    // strobe tied to a command that was latched as a write. Every other cycle
    // is a side-effect-free read.
    assign mem_address      = addr_q;
    assign mem_write_data   = wdata;
    assign mem_write_enable = (state == WR) && write_q && wvalid;

    assign req_ready = (state == IDLE);
    assign wready    = (state == WR);
    assign busy      = (state != IDLE);
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign done      = done_q;

endmodule

// File: tb/tb_memory_8x32_ctrl.sv
// ---------------------------------------------------------------------------
// tb_memory_8x32_ctrl
//
// Self-checking bench for memory_8x32_ctrl. A behavioural 8x32 synchronous
// SRAM sits on the memory port. When stimulus is driven, the expected SRAM
// writes and read beats are queued. A negedge monitor pops the queues and
// compares them whenever the DUT performs a write or hands over a read beat.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_memory_8x32_ctrl;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] req_len;
    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic              done;
    logic              busy;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_write_enable;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_item_t;

    wr_item_t    wq[$];
    logic [31:0] rq[$];
    logic [31:0] exp_mem [8];
    logic [31:0] sram [8];
    logic [31:0] wbuf [8];
    wr_item_t    mon_w;
    logic [31:0] mon_r;
    int          total = 0;
    int          bad = 0;
    int          write_count = 0;
    int          wc0;

    memory_8x32_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_len          (req_len),
        .wvalid           (wvalid),
        .wready           (wready),
        .wdata            (wdata),
        .rvalid           (rvalid),
        .rready           (rready),
        .rdata            (rdata),
        .done             (done),
        .busy             (busy),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous SRAM: one-cycle read latency, write on we=1.
    always @(posedge clk) begin
        if (mem_write_enable) begin
            sram[mem_address] <= mem_write_data;
        end
        mem_read_data <= sram[mem_address];
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: sampled mid-cycle, the handshake completes on the next posedge.
    always @(negedge clk) begin
        if (mem_write_enable) begin
            write_count++;
            if (wq.size() == 0) begin
                checkOutput("wr_extra", wq.size(), 1);
            end else begin
                mon_w = wq.pop_front();
                checkOutput("wr_addr", {29'd0, mem_address}, {29'd0, mon_w.addr});
                checkOutput("wr_data", mem_write_data, mon_w.data);
            end
        end
        if (rvalid && rready) begin
            if (rq.size() == 0) begin
                checkOutput("rd_extra", rq.size(), 1);
            end else begin
                mon_r = rq.pop_front();
                checkOutput("rd_data", rdata, mon_r);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command; called and returns at posedge+1.
    task automatic applyStimulus(input logic wr, input logic [2:0] addr, input logic [2:0] len);
        int n = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_len   = len;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("cmd_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        checkOutput("cmd_busy", busy, 1);
    endtask

    task automatic write_beats(input logic [2:0] addr, input int nbeats,
                               input logic [31:0] data [8], input int gap);
        applyStimulus(1'b1, addr, 3'(nbeats - 1));
        for (int i = 0; i < nbeats; i++) begin
            logic [2:0] a;
            a = addr + 3'(i);
            wvalid = 1'b1;
            wdata  = data[i];
            wq.push_back({a, data[i]});
            exp_mem[a] = data[i];
            @(negedge clk);
            checkOutput("wready", wready, 1);
            tick();
            if (i == 0 && gap > 0 && nbeats > 1) begin
                wvalid = 1'b0;
                wdata  = 32'hBAD0BAD0;
                repeat (gap) tick();
            end
        end
        wvalid = 1'b0;
        @(negedge clk);
        checkOutput("wr_done", done, 1);
        checkOutput("wr_idle", busy, 0);
        checkOutput("wr_req_ready", req_ready, 1);
        tick();
        @(negedge clk);
        checkOutput("wr_done_width", done, 0);
        tick();
    endtask

    task automatic read_burst(input logic [2:0] addr, input logic [2:0] len, input int stall);
        int n;
        for (int i = 0; i <= int'(len); i++) begin
            rq.push_back(exp_mem[3'(addr + 3'(i))]);
        end
        rready = (stall == 0);
        applyStimulus(1'b0, addr, len);
        checkOutput("rd_addr", {29'd0, mem_address}, {29'd0, addr});
        checkOutput("rd_no_we", mem_write_enable, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rvalid && n < 20);
        checkOutput("rd_latency", n, 3);
        for (int s = 0; s < stall; s++) begin
            checkOutput("hold_valid", rvalid, 1);
            checkOutput("hold_data", rdata, rq[0]);
            checkOutput("hold_addr", {29'd0, mem_address}, {29'd0, addr});
            @(posedge clk);
            #1;
            if (s == stall - 1) rready = 1'b1;
            @(negedge clk);
        end
        n = 0;
        while (rq.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        checkOutput("rd_drain", rq.size(), 0);
        @(negedge clk);
        checkOutput("rd_done", done, 1);
        checkOutput("rd_rvalid_low", rvalid, 0);
        tick();
        @(negedge clk);
        checkOutput("rd_done_width", done, 0);
        tick();
        rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        wvalid    = 1'b0;
        wdata     = '0;
        rready    = 1'b0;
        for (int i = 0; i < 8; i++) exp_mem[i] = '0;

        // Reset values, and no command accepted while held in reset.
        #3;
        checkOutput("rst_rvalid", rvalid, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_we", mem_write_enable, 0);
        checkOutput("rst_req_ready", req_ready, 1);
        checkOutput("rst_rdata", rdata, 0);
        checkOutput("rst_addr", {29'd0, mem_address}, 0);
        req_valid = 1'b1;
        req_write = 1'b1;
        repeat (2) tick();
        checkOutput("rst_no_accept", busy, 0);
        req_valid = 1'b0;
        req_write = 1'b0;
        reset_n   = 1'b1;
        tick();

        // Full-depth write first so every location holds a known value.
        for (int i = 0; i < 8; i++) wbuf[i] = 32'(i) * 32'h01010101;
        write_beats(3'd0, 8, wbuf, 0);
        read_burst(3'd3, 3'd7, 0);

        // Single write then read.
        wbuf[0] = 32'hDEADBEEF;
        write_beats(3'd5, 1, wbuf, 0);
        read_burst(3'd5, 3'd0, 0);

        // Wrap-around burst.
        wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
        write_beats(3'd6, 4, wbuf, 0);
        read_burst(3'd6, 3'd3, 0);

        // Backpressure on beat 0 of a two-beat read.
        read_burst(3'd0, 3'd1, 5);

        // Write with a one-cycle wvalid gap: exactly two SRAM writes.
        wc0 = write_count;
        wbuf[0] = 32'hCAFE0001; wbuf[1] = 32'hCAFE0002;
        write_beats(3'd4, 2, wbuf, 1);
        checkOutput("wr_count", write_count - wc0, 2);

        // Reset between beats of a four-beat write: only two beats land.
        wbuf[0] = 32'hA0A0A0A0; wbuf[1] = 32'hA1A1A1A1;
        applyStimulus(1'b1, 3'd2, 3'd3);
        for (int i = 0; i < 2; i++) begin
            wvalid = 1'b1;
            wdata  = wbuf[i];
            wq.push_back({3'(3'd2 + 3'(i)), wbuf[i]});
            exp_mem[3'd2 + 3'(i)] = wbuf[i];
            tick();
        end
        wvalid = 1'b1;
        wdata  = 32'hA2A2A2A2;
        #2 reset_n = 1'b0;
        #1;
        checkOutput("abort_wr_we", mem_write_enable, 0);
        checkOutput("abort_wr_busy", busy, 0);
        checkOutput("abort_wr_wready", wready, 0);
        wvalid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        read_burst(3'd2, 3'd3, 0);

        // Reset while a read beat is pending: rvalid clears without handshake.
        rq.push_back(exp_mem[1]);
        rready = 1'b0;
        applyStimulus(1'b0, 3'd1, 3'd2);
        n = 0;
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abort_rd_pending", rvalid, 1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("abort_rd_rvalid", rvalid, 0);
        checkOutput("abort_rd_busy", busy, 0);
        checkOutput("abort_rd_done", done, 0);
        checkOutput("abort_rd_we", mem_write_enable, 0);
        rq.delete();
        tick();
        reset_n = 1'b1;
        tick();
        read_burst(3'd7, 3'd1, 0);

        checkOutput("wq_empty", wq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
